// File: rtl/presence_counter_if.sv
// rtl/presence_counter_if.sv - sensor/clear inputs and BCD/blanking outputs of presence_counter
interface presence_counter_if;
    logic       sensor_in;
    logic       clr;
    logic [3:0] dig3;
    logic [3:0] dig2;
    logic [3:0] dig1;
    logic [3:0] dig0;
    logic       M;
    logic       det_pulse;

    modport master (
        output sensor_in, clr,
        input  dig3, dig2, dig1, dig0, M, det_pulse
    );

    modport slave (
        input  sensor_in, clr,
        output dig3, dig2, dig1, dig0, M, det_pulse
    );
endinterface

// File: rtl/presence_counter.sv
// rtl/presence_counter.sv - PIR sync/debounce, 4-digit BCD detection count, display blanking FSM
// Optional COUNT_SATURATE_EN: count holds at 9999 instead of wrapping to 0000.
module presence_counter #(
    parameter int CLK_HZ       = 50_000_000,
    parameter int DEBOUNCE_CYC = 500_000,
    parameter int TIMEOUT_S    = 30
) (
    input  logic                clk,
    input  logic                reset,
    presence_counter_if.slave   bus
);
    localparam int PW = $clog2(CLK_HZ + 1);
    localparam int DW = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
    localparam logic [DW-1:0] DB_MAX    = DW'(DEBOUNCE_CYC - 1);
    localparam logic [7:0]    TMO_LOAD  = 8'(TIMEOUT_S);

    typedef enum logic {SLEEP, ACTIVE} state_t;

    logic          r_sync1;
    logic          r_s_sync;
    logic [DW-1:0] r_db_cnt;
    logic          r_db_level;
    logic          r_db_prev;
    logic          r_det_pulse;
    logic [15:0]   r_bcd;
    logic [PW-1:0] r_presc;
    logic [7:0]    r_timeout;
    state_t        r_state;
    logic          r_m;

    logic [15:0]   w_bcd_inc;
    logic          w_at_max;
    logic          w_tick;

    assign w_tick = (r_presc == PRESC_MAX);

    // Ripple-carry BCD increment: each digit wraps 9->0 and passes the carry upward.
    always_comb begin
        logic v_carry;
        w_bcd_inc = r_bcd;
        v_carry   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (v_carry) begin
                if (r_bcd[i*4 +: 4] == 4'd9) begin
                    w_bcd_inc[i*4 +: 4] = 4'd0;
                end else begin
                    w_bcd_inc[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd1;
                    v_carry = 1'b0;
                end
            end
        end
    end

`ifdef COUNT_SATURATE_EN
    assign w_at_max = (r_bcd == 16'h9999);
`else
    assign w_at_max = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1     <= 1'b0;
            r_s_sync    <= 1'b0;
            r_db_cnt    <= '0;
            r_db_level  <= 1'b0;
            r_db_prev   <= 1'b0;
            r_det_pulse <= 1'b0;
            r_bcd       <= '0;
            r_presc     <= '0;
            r_timeout   <= '0;
            r_state     <= SLEEP;
            r_m         <= 1'b0;
        end else begin
            r_sync1  <= bus.sensor_in;
            r_s_sync <= r_sync1;

            // Level must disagree for DEBOUNCE_CYC consecutive samples before it is accepted.
            if (r_s_sync == r_db_level) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DB_MAX) begin
                r_db_cnt   <= '0;
                r_db_level <= ~r_db_level;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end

            r_db_prev   <= r_db_level;
            r_det_pulse <= r_db_level & ~r_db_prev;

            if (bus.clr) begin
                r_bcd <= '0;
            end else if (r_det_pulse && !w_at_max) begin
                r_bcd <= w_bcd_inc;
            end

            r_presc <= w_tick ? '0 : r_presc + 1'b1;

            if (r_db_level) begin
                r_timeout <= TMO_LOAD;
            end else if (w_tick && r_timeout != 8'd0) begin
                r_timeout <= r_timeout - 8'd1;
            end

            case (r_state)
                SLEEP: begin
                    if (r_det_pulse) begin
                        r_state <= ACTIVE;
                        r_m     <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (r_timeout == 8'd0 && !r_db_level) begin
                        r_state <= SLEEP;
                        r_m     <= 1'b0;
                    end
                end
                default: begin
                    r_state <= SLEEP;
                    r_m     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.dig3      = r_bcd[15:12];
    assign bus.dig2      = r_bcd[11:8];
    assign bus.dig1      = r_bcd[7:4];
    assign bus.dig0      = r_bcd[3:0];
    assign bus.M         = r_m;
    assign bus.det_pulse = r_det_pulse;
endmodule
